// File: rtl/raster_quad_serializer.sv
// raster_quad_serializer: captures one batch of evaluated quads and emits the
// overlapping ones one per cycle, lowest index first, over valid/ready.
//
// Ports:
//   clk, reset (async, active-low)
//   valid_in/ready_in + pid_in, overlap_in, mask_in, xloc_in, yloc_in,
//     bcoords_in : batch input handshake and per-quad fields
//   valid_out/ready_out + pid_out, mask_out, xloc_out, yloc_out,
//     bcoords_out, last_out : one-quad-per-cycle output stream
module raster_quad_serializer #(
   parameter int NUM_QUADS = 4,
   parameter int DIM_BITS  = 16,
   parameter int DATA_BITS = 32,
   parameter int PID_BITS  = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              valid_in,
   output logic                              ready_in,
   input  logic [PID_BITS-1:0]               pid_in,
   input  logic [NUM_QUADS-1:0]              overlap_in,
   input  logic [NUM_QUADS*4-1:0]            mask_in,
   input  logic [NUM_QUADS*DIM_BITS-1:0]     xloc_in,
   input  logic [NUM_QUADS*DIM_BITS-1:0]     yloc_in,
   input  logic [NUM_QUADS*12*DATA_BITS-1:0] bcoords_in,
   output logic                              valid_out,
   input  logic                              ready_out,
   output logic [PID_BITS-1:0]               pid_out,
   output logic [3:0]                        mask_out,
   output logic [DIM_BITS-1:0]               xloc_out,
   output logic [DIM_BITS-1:0]               yloc_out,
   output logic [12*DATA_BITS-1:0]           bcoords_out,
   output logic                              last_out
);

   localparam int BCW  = 12 * DATA_BITS;
   localparam int SELW = (NUM_QUADS > 1) ? $clog2(NUM_QUADS) : 1;

   logic [PID_BITS-1:0]           pid_q, pid_d;
   logic [NUM_QUADS-1:0]          pending_q, pending_d;
   logic [NUM_QUADS*4-1:0]        mask_q, mask_d;
   logic [NUM_QUADS*DIM_BITS-1:0] xloc_q, xloc_d;
   logic [NUM_QUADS*DIM_BITS-1:0] yloc_q, yloc_d;
   logic [NUM_QUADS*BCW-1:0]      bc_q, bc_d;

   logic [SELW-1:0] sel;
   int              sel_i;
   logic            out_fire;
   logic            in_fire;

   // Lowest set bit wins: scan from the top so lower indices overwrite.
   always_comb begin
      sel = '0;
      for (int i = NUM_QUADS - 1; i >= 0; i--) begin
         if (pending_q[i]) sel = SELW'(i);
      end
   end

   assign sel_i = int'(sel);

   // Exactly one pending bit: clearing the lowest set bit leaves nothing.
   assign valid_out = |pending_q;
   assign last_out  = valid_out &&
                      ((pending_q & (pending_q - NUM_QUADS'(1))) == '0);
   assign out_fire  = valid_out && ready_out;

   // Accepting on the final fire gives back-to-back batches with no bubble.
   assign ready_in  = !valid_out || (out_fire && last_out);
   assign in_fire   = valid_in && ready_in;

   always_comb begin
      pid_out     = '0;
      mask_out    = '0;
      xloc_out    = '0;
      yloc_out    = '0;
      bcoords_out = '0;
      if (valid_out) begin
         pid_out     = pid_q;
         mask_out    = mask_q[sel_i*4 +: 4];
         xloc_out    = xloc_q[sel_i*DIM_BITS +: DIM_BITS];
         yloc_out    = yloc_q[sel_i*DIM_BITS +: DIM_BITS];
         bcoords_out = bc_q[sel_i*BCW +: BCW];
      end
   end

   // A new batch overrides the clear of the last quad of the old one.
   always_comb begin
      pid_d     = pid_q;
      pending_d = pending_q;
      mask_d    = mask_q;
      xloc_d    = xloc_q;
      yloc_d    = yloc_q;
      bc_d      = bc_q;
      if (in_fire) begin
         pid_d     = pid_in;
         pending_d = overlap_in;
         mask_d    = mask_in;
         xloc_d    = xloc_in;
         yloc_d    = yloc_in;
         bc_d      = bcoords_in;
      end else if (out_fire) begin
         pending_d[sel] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pid_q     <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         xloc_q    <= '0;
         yloc_q    <= '0;
         bc_q      <= '0;
      end else begin
         pid_q     <= pid_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         xloc_q    <= xloc_d;
         yloc_q    <= yloc_d;
         bc_q      <= bc_d;
      end
   end

endmodule

// File: tb/tb_raster_quad_serializer.sv
// tb_raster_quad_serializer: directed and randomized stimulus for
// raster_quad_serializer, checked against a queue-based model every cycle.
module tb_raster_quad_serializer;

   localparam int NQ  = 4;
   localparam int DB  = 16;
   localparam int BCW = 384;

   logic            clk;
   logic            rst_n;
   logic            valid_in;
   logic            ready_in;
   logic [7:0]      pid_in;
   logic [NQ-1:0]   overlap_in;
   logic [NQ*4-1:0] mask_in;
   logic [NQ*DB-1:0] xloc_in;
   logic [NQ*DB-1:0] yloc_in;
   logic [NQ*BCW-1:0] bcoords_in;
   logic            valid_out;
   logic            ready_out;
   logic [7:0]      pid_out;
   logic [3:0]      mask_out;
   logic [DB-1:0]   xloc_out;
   logic [DB-1:0]   yloc_out;
   logic [BCW-1:0]  bcoords_out;
   logic            last_out;

   int checks = 0;
   int errors = 0;

   raster_quad_serializer dut (
      .clk        (clk),
      .reset      (rst_n),
      .valid_in   (valid_in),
      .ready_in   (ready_in),
      .pid_in     (pid_in),
      .overlap_in (overlap_in),
      .mask_in    (mask_in),
      .xloc_in    (xloc_in),
      .yloc_in    (yloc_in),
      .bcoords_in (bcoords_in),
      .valid_out  (valid_out),
      .ready_out  (ready_out),
      .pid_out    (pid_out),
      .mask_out   (mask_out),
      .xloc_out   (xloc_out),
      .yloc_out   (yloc_out),
      .bcoords_out(bcoords_out),
      .last_out   (last_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [BCW-1:0] act,
                      input logic [BCW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_batch(input logic [7:0] p, input logic [3:0] ov,
                            input int xb, input int xs);
      valid_in   = 1'b1;
      pid_in     = p;
      overlap_in = ov;
      for (int i = 0; i < NQ; i++) begin
         xloc_in[i*DB +: DB] = 16'(xb + i * xs);
         yloc_in[i*DB +: DB] = 16'(xb + i * xs + 500);
         mask_in[i*4 +: 4]   = 4'($urandom);
         for (int w = 0; w < 12; w++)
            bcoords_in[i*BCW + w*32 +: 32] = $urandom;
      end
   endtask

   // Model: the current batch contents plus the ordered list of quad
   // indices still to be emitted.
   int               q[$];
   logic [7:0]       m_pid;
   logic [3:0]       m_mask[NQ];
   logic [DB-1:0]    m_x[NQ];
   logic [DB-1:0]    m_y[NQ];
   logic [BCW-1:0]   m_bc[NQ];

   initial begin
      forever begin
         logic e_valid, e_last, e_rdy;
         @(negedge clk);
         if (!rst_n) q.delete();
         e_valid = (q.size() > 0);
         e_last  = (q.size() == 1);
         e_rdy   = (q.size() == 0) || (ready_out && q.size() == 1);
         chk("m_valid_out", valid_out, e_valid);
         chk("m_last_out", last_out, e_last);
         chk("m_ready_in", ready_in, e_rdy);
         if (e_valid) begin
            chk("m_pid_out", pid_out, m_pid);
            chk("m_mask_out", mask_out, m_mask[q[0]]);
            chk("m_xloc_out", xloc_out, m_x[q[0]]);
            chk("m_yloc_out", yloc_out, m_y[q[0]]);
            chk("m_bcoords_out", bcoords_out, m_bc[q[0]]);
         end
         if (rst_n) begin
            if (valid_in && e_rdy) begin
               q.delete();
               m_pid = pid_in;
               for (int i = 0; i < NQ; i++) begin
                  if (overlap_in[i]) q.push_back(i);
                  m_mask[i] = mask_in[i*4 +: 4];
                  m_x[i]    = xloc_in[i*DB +: DB];
                  m_y[i]    = yloc_in[i*DB +: DB];
                  m_bc[i]   = bcoords_in[i*BCW +: BCW];
               end
            end else if (e_valid && ready_out) begin
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      int bp_rdy[6];
      int bp_x[6];
      int fires;
      rst_n      = 1'b0;
      valid_in   = 1'b0;
      ready_out  = 1'b1;
      pid_in     = '0;
      overlap_in = '0;
      mask_in    = '0;
      xloc_in    = '0;
      yloc_in    = '0;
      bcoords_in = '0;

      // Reset held with a batch offered.
      set_batch(8'd1, 4'b0001, 16'h55, 1);
      repeat (3) tick();
      #1;
      chk("rst_valid_out", valid_out, 0);
      chk("rst_ready_in", ready_in, 1);
      chk("rst_last_out", last_out, 0);
      chk("rst_xloc_out", xloc_out, 0);
      chk("rst_pid_out", pid_out, 0);
      chk("rst_mask_out", mask_out, 0);
      chk("rst_bcoords_out", bcoords_out, 0);
      tick();
      rst_n = 1'b1;
      tick();
      valid_in = 1'b0;
      #1;
      chk("single_valid", valid_out, 1);
      chk("single_last", last_out, 1);
      chk("single_x", xloc_out, 16'h55);
      tick();
      #1;
      chk("single_done", valid_out, 0);

      // Ordering.
      set_batch(8'd7, 4'b1010, 0, 10);
      tick();
      valid_in = 1'b0;
      #1;
      chk("ord_x0", xloc_out, 10);
      chk("ord_last0", last_out, 0);
      chk("ord_pid0", pid_out, 7);
      chk("ord_rdy0", ready_in, 0);
      tick();
      #1;
      chk("ord_x1", xloc_out, 30);
      chk("ord_last1", last_out, 1);
      chk("ord_pid1", pid_out, 7);
      chk("ord_rdy1", ready_in, 1);
      tick();
      #1;
      chk("ord_done", valid_out, 0);

      // Backpressure.
      bp_rdy = '{1, 0, 0, 1, 1, 1};
      bp_x   = '{100, 101, 101, 101, 102, 103};
      fires  = 0;
      set_batch(8'd3, 4'b1111, 100, 1);
      tick();
      valid_in = 1'b0;
      for (int k = 0; k < 6; k++) begin
         ready_out = bp_rdy[k][0];
         #1;
         chk("bp_x", xloc_out, 16'(bp_x[k]));
         if (valid_out && ready_out) fires++;
         tick();
      end
      ready_out = 1'b1;
      #1;
      chk("bp_fires", fires, 4);
      chk("bp_done", valid_out, 0);

      // Back-to-back.
      set_batch(8'd9, 4'b0110, 200, 1);
      tick();
      set_batch(8'd10, 4'b1001, 300, 1);
      #1;
      chk("b2b_x1", xloc_out, 201);
      chk("b2b_last1", last_out, 0);
      chk("b2b_rdy1", ready_in, 0);
      tick();
      #1;
      chk("b2b_x2", xloc_out, 202);
      chk("b2b_last2", last_out, 1);
      chk("b2b_rdy2", ready_in, 1);
      tick();
      valid_in = 1'b0;
      #1;
      chk("b2b_x3", xloc_out, 300);
      chk("b2b_last3", last_out, 0);
      chk("b2b_pid3", pid_out, 10);
      tick();
      #1;
      chk("b2b_x4", xloc_out, 303);
      chk("b2b_last4", last_out, 1);
      tick();
      #1;
      chk("b2b_done", valid_out, 0);

      // Empty batch then a one-quad batch.
      set_batch(8'd11, 4'b0000, 400, 1);
      #1;
      chk("empty_rdy0", ready_in, 1);
      tick();
      set_batch(8'd12, 4'b0100, 400, 1);
      #1;
      chk("empty_valid", valid_out, 0);
      chk("empty_rdy1", ready_in, 1);
      tick();
      valid_in = 1'b0;
      #1;
      chk("empty_x", xloc_out, 402);
      chk("empty_last", last_out, 1);
      tick();
      #1;
      chk("empty_done", valid_out, 0);

      // Reset mid-batch.
      set_batch(8'd13, 4'b1111, 500, 1);
      tick();
      valid_in = 1'b0;
      #1;
      chk("mid_x0", xloc_out, 500);
      tick();
      #1;
      chk("mid_x1", xloc_out, 501);
      tick();
      #1;
      chk("mid_x2", xloc_out, 502);
      rst_n = 1'b0;
      #1;
      chk("mid_async_valid", valid_out, 0);
      chk("mid_async_rdy", ready_in, 1);
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("mid_no_resume", valid_out, 0);
         tick();
      end

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 1) == 1)
            set_batch(8'($urandom), 4'($urandom), int'($urandom_range(0, 60000)), 1);
         else
            valid_in = 1'b0;
         ready_out = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 399) != 0);
         tick();
      end
      rst_n    = 1'b1;
      valid_in = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/raster_quad_serializer.md
Name: raster_quad_serializer

Overview:
- Sits directly downstream of the rasterizer quad evaluator.
- Captures one batch of NUM_QUADS evaluated quads, with their per-quad overlap flags, masks, locations and barycentric edge values. Discards the non-overlapping quads and emits the overlapping ones one per cycle, lowest index first, over a valid/ready interface toward the raster output queue.
- Can accept a new batch back-to-back with the last emission of the previous batch.

Parameters:
- NUM_QUADS, 4, quads per input batch (1..16).
- DIM_BITS, 16, width of quad x/y location.
- DATA_BITS, 32, width of one edge/bcoord value.
- PID_BITS, 8, primitive id width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- valid_in  in  1  batch valid.
- ready_in  out  1  batch accepted when valid_in && ready_in.
- pid_in  in  PID_BITS  primitive id of batch.
- overlap_in  in  NUM_QUADS  per-quad overlap flag.
- mask_in  in  NUM_QUADS*4  per-quad 2x2 pixel mask.
- xloc_in  in  NUM_QUADS*DIM_BITS  quad x.
- yloc_in  in  NUM_QUADS*DIM_BITS  quad y.
- bcoords_in  in  NUM_QUADS*3*4*DATA_BITS  per-quad edge values [quad][edge][pixel].
- valid_out  out  1  quad valid.
- ready_out  in  1  downstream ready.
- pid_out  out  PID_BITS  primitive id.
- mask_out  out  4  pixel mask.
- xloc_out  out  DIM_BITS  quad x.
- yloc_out  out  DIM_BITS  quad y.
- bcoords_out  out  3*4*DATA_BITS  edge values.
- last_out  out  1  this is the last overlapping quad of its batch.

Behaviour:
- State: holding registers for all batch fields, plus pending[NUM_QUADS].
- Reset (reset==0, async): pending=0 and all holding registers are 0. All outputs read 0 and ready_in=1. Any batch in flight is lost, with no partial emission after release.
- Emission is combinational from the holding registers:
  - valid_out = |pending.
  - sel = index of the lowest set bit of pending.
  - Outputs carry the sel quad's fields plus the held pid.
  - last_out = valid_out && (pending has exactly one bit set).
  - When valid_out=0, data outputs are don't-care (reset value 0) and last_out=0.
- Output fire = valid_out && ready_out. On fire, pending[sel] clears at the next edge.
- Outputs are stable while valid_out=1 && ready_out=0. No bit may be dropped or reordered under backpressure.
- ready_in = (pending==0) || (fire && last_out). This is a combinational path from ready_out to ready_in; it is required for back-to-back operation.
- Input fire = valid_in && ready_in. On the next edge the block loads all fields and sets pending=overlap_in.
  - If fire and last_out are both true in the same cycle, the load wins: the new batch replaces the old.
- Latency: a batch accepted in cycle N presents its first quad in N+1.
  - Throughput is one quad per cycle.
  - A batch with k overlapping quads occupies k cycles with no bubble between batches.
- overlap_in==0 batch: accepted in one cycle and produces no output. pending stays 0, so ready_in stays 1 in the following cycle.
- mask_in, xloc_in, yloc_in and bcoords_in are passed through unmodified. There is no arithmetic, and overlap_in is trusted as given.
- valid_in may drop without handshake. No protocol assumption is made upstream.

Test Plan:
- Reset: hold reset=0 for 3 cycles with valid_in=1 → valid_out=0, ready_in=1, all outputs 0. Release, present overlap_in=4'b0001 → single quad emitted next cycle with last_out=1.
- Ordering: overlap_in=4'b1010, pid=7, xloc={30,20,10,0}, ready_out=1 → quad1 (x=10, last_out=0) then quad3 (x=30, last_out=1) in consecutive cycles, pid_out=7. ready_in=0 in the first of those cycles and 1 in the second.
- Backpressure: overlap_in=4'b1111, ready_out toggles 1,0,0,1,1,1 → quads 0,1,1,1,2,3 appear on the outputs. Exactly 4 fires, and outputs are unchanged during stalls.
- Back-to-back: two batches, overlap 4'b0110 then 4'b1001, valid_in held high, ready_out=1 → output indices 1,2,0,3 on 4 consecutive cycles with no bubble. last_out=1 on cycles 2 and 4.
- Empty batch: overlap_in=0 followed by overlap_in=4'b0100 on consecutive cycles → both accepted on consecutive cycles; only quad2 is emitted, one cycle after the second accept.
- Reset mid-batch: overlap_in=4'b1111 with 2 quads emitted, then assert reset → valid_out=0 immediately (async). After release, no remaining quad from that batch is emitted.
